ahb_mul_engine: RTL and testbench

AHB_MUL_ENGINE -- requirements
Module: ahb_mul_engine

---
 rtl/ahb_mul_engine.sv | 121 ++++++++++++
 tb/tb_ahb_mul_engine.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/ahb_mul_engine.sv
// ahb_mul_engine: AHB-Lite slave wrapping a radix-2 shift-add multiplier.
// Registers OPA/OPB/CTRL/RES_LO/RES_HI; a start write runs one multiply.
module ahb_mul_engine #(
  parameter int          WIDTH     = 16,
  parameter logic [15:0] BASE_MASK = 16'h00FF
) (
  input  logic        AHB_HCLK,
  input  logic        AHB_HRESETn,
  input  logic        AHB_HSEL,
  input  logic        AHB_HWRITE,
  input  logic [1:0]  AHB_HTRANS,
  input  logic [31:0] AHB_HADDR,
  input  logic [31:0] AHB_HWDATA,
  input  logic [2:0]  AHB_HSIZE,
  input  logic [2:0]  AHB_HBURST,
  input  logic [3:0]  AHB_HPROT,
  input  logic [3:0]  AHB_HMASTER,
  input  logic        AHB_HMASTLOCK,
  output logic [31:0] AHB_HRDATA,
  output logic        AHB_HREADY,
  output logic [1:0]  AHB_HRESP,
  output logic        irq,
  output logic        busy
);
  localparam int PW = 2 * WIDTH;
  typedef enum logic [1:0] {IDLE, LOAD, RUN, FIN} state_t;
  state_t state_q, state_d;
  logic [15:0] off_q, off_d;
  logic wr_q, wr_d, rd_q, rd_d;
  logic [WIDTH-1:0] opa_q, opa_d, opb_q, opb_d, mplier_q, mplier_d, amag, bmag;
  logic done_q, done_d, smode_q, smode_d, irq_en_q, irq_en_d, sign_q, sign_d;
  logic [PW-1:0] mcand_q, mcand_d, acc_q, acc_d, res_q, res_d;
  logic [5:0] cnt_q, cnt_d;
  logic [63:0] res64;
  logic [31:0] rdata;
  logic s_load, s_run, s_fin, ctrl_wr, start;
  logic unused;
  assign unused = ^{AHB_HSIZE, AHB_HBURST, AHB_HPROT, AHB_HMASTER, AHB_HMASTLOCK,
                    AHB_HADDR, AHB_HWDATA};
  assign ctrl_wr = wr_q && off_q == 16'h0008;
  assign start   = ctrl_wr && AHB_HWDATA[0] && state_q == IDLE;
  always_ff @(posedge AHB_HCLK or negedge AHB_HRESETn)
    if (!AHB_HRESETn) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = LOAD;
      LOAD: state_d = RUN;
      RUN:  if (cnt_q == 6'(WIDTH - 1)) state_d = FIN;
      FIN:  state_d = IDLE;
    endcase
  end
  always_comb begin
    s_load = state_q == LOAD;
    s_run  = state_q == RUN;
    s_fin  = state_q == FIN;
    busy   = state_q != IDLE;
  end
  always_comb begin
    off_d    = AHB_HADDR[15:0] & BASE_MASK;
    wr_d     = AHB_HSEL & AHB_HTRANS[1] & AHB_HWRITE;
    rd_d     = AHB_HSEL & AHB_HTRANS[1] & ~AHB_HWRITE;
    opa_d    = (wr_q && off_q == 16'h0000) ? AHB_HWDATA[WIDTH-1:0] : opa_q;
    opb_d    = (wr_q && off_q == 16'h0004) ? AHB_HWDATA[WIDTH-1:0] : opb_q;
    smode_d  = ctrl_wr ? AHB_HWDATA[3] : smode_q;
    irq_en_d = ctrl_wr ? AHB_HWDATA[4] : irq_en_q;
    // completion wins over a same-cycle clear so a finished result is never missed
    done_d   = s_fin ? 1'b1 : (ctrl_wr && (AHB_HWDATA[1] || start)) ? 1'b0 : done_q;
    amag     = (smode_q && opa_q[WIDTH-1]) ? -opa_q : opa_q;
    bmag     = (smode_q && opb_q[WIDTH-1]) ? -opb_q : opb_q;
    sign_d   = s_load ? smode_q & (opa_q[WIDTH-1] ^ opb_q[WIDTH-1]) : sign_q;
    mcand_d  = s_load ? PW'(amag) : s_run ? mcand_q << 1 : mcand_q;
    mplier_d = s_load ? bmag : s_run ? mplier_q >> 1 : mplier_q;
    acc_d    = s_load ? '0 : (s_run && mplier_q[0]) ? acc_q + mcand_q : acc_q;
    cnt_d    = s_load ? '0 : s_run ? cnt_q + 6'd1 : cnt_q;
    res_d    = s_fin ? (sign_q ? -acc_q : acc_q) : res_q;
    res64    = 64'(res_q);
    rdata    = off_q == 16'h0000 ? 32'(opa_q) :
               off_q == 16'h0004 ? 32'(opb_q) :
               off_q == 16'h0008 ? {27'd0, irq_en_q, smode_q, busy, done_q, 1'b0} :
               off_q == 16'h000C ? res64[31:0] :
               off_q == 16'h0010 ? res64[63:32] : 32'h0;
  end
  always_ff @(posedge AHB_HCLK or negedge AHB_HRESETn)
    if (!AHB_HRESETn) begin
      off_q    <= '0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      opa_q    <= '0;
      opb_q    <= '0;
      done_q   <= 1'b0;
      smode_q  <= 1'b0;
      irq_en_q <= 1'b0;
      sign_q   <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      res_q    <= '0;
    end else begin
      off_q    <= off_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      done_q   <= done_d;
      smode_q  <= smode_d;
      irq_en_q <= irq_en_d;
      sign_q   <= sign_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      res_q    <= res_d;
    end
  assign AHB_HRDATA = rd_q ? rdata : 32'h0;
  assign AHB_HREADY = 1'b1;
  assign AHB_HRESP  = 2'b00;
  assign irq        = done_q & irq_en_q;
endmodule

// File: tb/tb_ahb_mul_engine.sv
// tb_ahb_mul_engine: directed bench for 8- and 32-bit multiplier instances
// sharing one AHB bus; read expectations flow through a scoreboard queue.
module tb_ahb_mul_engine;
  logic hclk = 1'b0, hresetn = 1'b0;
  logic hsel8 = 1'b0, hsel32 = 1'b0, hwrite = 1'b0;
  logic [1:0] htrans = 2'b00;
  logic [31:0] haddr = '0, hwdata = '0;
  logic [31:0] rdata8, rdata32;
  logic ready8, ready32, irq8, irq32, busy8, busy32;
  logic [1:0] resp8, resp32;
  logic [31:0] exp_q[$];
  string tag_q[$];
  int compared = 0, mismatched = 0;
  always #5 hclk = ~hclk;
  ahb_mul_engine #(.WIDTH(8)) u8 (
    .AHB_HCLK(hclk), .AHB_HRESETn(hresetn), .AHB_HSEL(hsel8), .AHB_HWRITE(hwrite),
    .AHB_HTRANS(htrans), .AHB_HADDR(haddr), .AHB_HWDATA(hwdata), .AHB_HSIZE(3'd2),
    .AHB_HBURST(3'd0), .AHB_HPROT(4'd3), .AHB_HMASTER(4'd0), .AHB_HMASTLOCK(1'b0),
    .AHB_HRDATA(rdata8), .AHB_HREADY(ready8), .AHB_HRESP(resp8), .irq(irq8), .busy(busy8));
  ahb_mul_engine #(.WIDTH(32)) u32 (
    .AHB_HCLK(hclk), .AHB_HRESETn(hresetn), .AHB_HSEL(hsel32), .AHB_HWRITE(hwrite),
    .AHB_HTRANS(htrans), .AHB_HADDR(haddr), .AHB_HWDATA(hwdata), .AHB_HSIZE(3'd2),
    .AHB_HBURST(3'd0), .AHB_HPROT(4'd3), .AHB_HMASTER(4'd0), .AHB_HMASTLOCK(1'b0),
    .AHB_HRDATA(rdata32), .AHB_HREADY(ready32), .AHB_HRESP(resp32), .irq(irq32), .busy(busy32));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  // upper address bits 0x1200 are outside BASE_MASK and must not affect decode
  task automatic wr(input bit w32, input logic [15:0] a, input logic [31:0] d);
    @(posedge hclk); #1;
    hsel8 = !w32; hsel32 = w32; htrans = 2'b10; hwrite = 1'b1; haddr = {16'h4000, 16'h1200 | a};
    @(posedge hclk); #1;
    hsel8 = 1'b0; hsel32 = 1'b0; htrans = 2'b00; hwrite = 1'b0; hwdata = d;
  endtask
  task automatic rd(input bit w32, input logic [15:0] a, input logic [31:0] exp, input string tag);
    @(posedge hclk); #1;
    hsel8 = !w32; hsel32 = w32; htrans = 2'b10; hwrite = 1'b0; haddr = {16'h4000, 16'h1200 | a};
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    @(posedge hclk); #1;
    hsel8 = 1'b0; hsel32 = 1'b0; htrans = 2'b00;
    chk(tag_q.pop_front(), w32 ? rdata32 : rdata8, exp_q.pop_front());
  endtask
  task automatic count_busy(input bit w32, output int n);
    n = 0;
    @(posedge hclk); #1;
    while ((w32 ? busy32 : busy8) && n < 200) begin
      n++;
      @(posedge hclk); #1;
    end
  endtask
  initial begin
    int n;
    logic [7:0] a, b;
    bit s;
    int sa, sb;
    logic [15:0] e;
    repeat (2) @(posedge hclk);
    #1;
    chk("rst_busy", {31'd0, busy8}, 32'd0);
    chk("rst_irq", {31'd0, irq8}, 32'd0);
    chk("rst_hrdata", rdata8, 32'd0);
    hresetn = 1'b1;
    chk("hready", {31'd0, ready8}, 32'd1);
    chk("hresp", {30'd0, resp8}, 32'd0);
    rd(0, 16'h00, 32'h0, "rst_opa");
    rd(0, 16'h04, 32'h0, "rst_opb");
    rd(0, 16'h08, 32'h0, "rst_ctrl");
    rd(0, 16'h0C, 32'h0, "rst_reslo");
    rd(0, 16'h10, 32'h0, "rst_reshi");
    wr(0, 16'h00, 32'h0000_01FF);
    rd(0, 16'h00, 32'h0000_00FF, "opa_trunc");
    // unsigned 200*150
    wr(0, 16'h00, 32'd200);
    wr(0, 16'h04, 32'd150);
    wr(0, 16'h08, 32'h01);
    count_busy(0, n);
    chk("busy_cycles8", n, 32'd10);
    rd(0, 16'h08, 32'h02, "done_set");
    rd(0, 16'h0C, 32'h0000_7530, "u_200x150_lo");
    rd(0, 16'h10, 32'h0, "u_200x150_hi");
    // signed -3*5 and -128*-128
    wr(0, 16'h00, 32'hFD);
    wr(0, 16'h04, 32'h05);
    wr(0, 16'h08, 32'h09);
    count_busy(0, n);
    rd(0, 16'h0C, 32'h0000_FFF1, "s_m3x5");
    rd(0, 16'h08, 32'h0A, "ctrl_signed_done");
    wr(0, 16'h00, 32'h80);
    wr(0, 16'h04, 32'h80);
    wr(0, 16'h08, 32'h09);
    count_busy(0, n);
    rd(0, 16'h0C, 32'h0000_4000, "s_min_sq");
    for (int i = 0; i < 6; i++) begin
      a = 8'($urandom); b = 8'($urandom); s = 1'($urandom);
      sa = s ? int'($signed(a)) : int'(a);
      sb = s ? int'($signed(b)) : int'(b);
      e = 16'(sa * sb);
      wr(0, 16'h00, {24'd0, a});
      wr(0, 16'h04, {24'd0, b});
      wr(0, 16'h08, s ? 32'h09 : 32'h01);
      count_busy(0, n);
      rd(0, 16'h0C, {16'd0, e}, "rand_prod");
    end
    // 32-bit full-scale unsigned
    wr(1, 16'h00, 32'hFFFF_FFFF);
    wr(1, 16'h04, 32'hFFFF_FFFF);
    wr(1, 16'h08, 32'h01);
    count_busy(1, n);
    chk("busy_cycles32", n, 32'd34);
    rd(1, 16'h10, 32'hFFFF_FFFE, "u32_hi");
    rd(1, 16'h0C, 32'h0000_0001, "u32_lo");
    // writes while busy: new OPA lands but the running op and its result are untouched
    wr(0, 16'h00, 32'd10);
    wr(0, 16'h04, 32'd3);
    wr(0, 16'h08, 32'h11);
    wr(0, 16'h00, 32'd99);
    wr(0, 16'h08, 32'h11);
    chk("irq_busy", {31'd0, irq8}, 32'd0);
    count_busy(0, n);
    chk("irq_done", {31'd0, irq8}, 32'd1);
    rd(0, 16'h0C, 32'd30, "busy_start_ignored");
    rd(0, 16'h00, 32'd99, "opa_busy_write");
    wr(0, 16'h08, 32'h12);
    @(posedge hclk); #1;
    chk("irq_cleared", {31'd0, irq8}, 32'd0);
    rd(0, 16'h08, 32'h10, "ctrl_after_clear");
    // done-clear landing in the FIN cycle leaves done set
    wr(0, 16'h08, 32'h01);
    repeat (8) @(posedge hclk);
    wr(0, 16'h08, 32'h02);
    rd(0, 16'h08, 32'h02, "fin_vs_clear");
    // start together with clear: runs, done reads 0
    wr(0, 16'h08, 32'h03);
    rd(0, 16'h08, 32'h04, "start_clear_busy");
    count_busy(0, n);
    rd(0, 16'h0C, 32'h0000_0129, "start_clear_res");
    // reset in RUN cycle 4
    wr(0, 16'h08, 32'h11);
    repeat (5) @(posedge hclk);
    #2 hresetn = 1'b0;
    #1;
    chk("rst_run_busy", {31'd0, busy8}, 32'd0);
    chk("rst_run_irq", {31'd0, irq8}, 32'd0);
    chk("rst_run_hrdata", rdata8, 32'd0);
    #4 hresetn = 1'b1;
    rd(0, 16'h0C, 32'h0, "rst_run_res");
    rd(0, 16'h08, 32'h0, "rst_run_ctrl");
    rd(0, 16'h00, 32'h0, "rst_run_opa");
    rd(0, 16'h20, 32'h0, "unmapped");
    wr(0, 16'h0C, 32'hDEAD_BEEF);
    rd(0, 16'h0C, 32'h0, "ro_write_ignored");
    wr(0, 16'h00, 32'd7);
    wr(0, 16'h04, 32'd9);
    wr(0, 16'h08, 32'h01);
    count_busy(0, n);
    chk("post_rst_cycles", n, 32'd10);
    rd(0, 16'h0C, 32'd63, "post_rst_res");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
